// File: rtl/io_ring_pkg.sv
// Shared defaults, counter limits and the filter-counter width helper for the pad-ring controller.
// Pure declarations: no logic, no latency.
package io_ring_pkg;

    localparam int N_IN_DEF        = 28;
    localparam int N_OUT_DEF       = 10;
    localparam int SYNC_STAGES_DEF = 2;
    localparam int FILT_LEN_DEF    = 4;

    localparam int              CNT_W   = 8;
    localparam logic [CNT_W-1:0] CNT_MAX = 8'hFF;

    // Counter must reach FILT_LEN-1; never narrower than one bit.
    function automatic int filt_cnt_w(input int filt_len);
        return (filt_len <= 2) ? 1 : $clog2(filt_len);
    endfunction

endpackage

// File: rtl/io_ring_ctrl_if.sv
// Pad-side and core-side signal bundle of io_ring_ctrl; master drives the inputs, slave is the controller.
// IO_LOOPBACK_EN adds the in_loopback select.
interface io_ring_ctrl_if import io_ring_pkg::*; #(
    parameter int N_IN  = N_IN_DEF,
    parameter int N_OUT = N_OUT_DEF
);

    logic [N_IN-1:0]  in_padIn;
    logic [N_IN-1:0]  out_coreIn;
    logic [N_OUT-1:0] in_coreOut;
    logic [N_OUT-1:0] out_padOut;
    logic             in_filtBypass;
    logic             in_outHold;
    logic             in_countClear;
    logic             out_inChange;
    logic [CNT_W-1:0] out_changeCount;

`ifdef IO_LOOPBACK_EN
    logic in_loopback;

    modport master (
        output in_padIn, in_coreOut, in_filtBypass, in_outHold, in_countClear, in_loopback,
        input  out_coreIn, out_padOut, out_inChange, out_changeCount
    );
    modport slave (
        input  in_padIn, in_coreOut, in_filtBypass, in_outHold, in_countClear, in_loopback,
        output out_coreIn, out_padOut, out_inChange, out_changeCount
    );
`else
    modport master (
        output in_padIn, in_coreOut, in_filtBypass, in_outHold, in_countClear,
        input  out_coreIn, out_padOut, out_inChange, out_changeCount
    );
    modport slave (
        input  in_padIn, in_coreOut, in_filtBypass, in_outHold, in_countClear,
        output out_coreIn, out_padOut, out_inChange, out_changeCount
    );
`endif

endinterface

// File: rtl/io_in_filter.sv
// One input channel: SYNC_STAGES-deep synchroniser followed by a FILT_LEN-cycle glitch filter.
// Latency SYNC_STAGES+FILT_LEN edges (SYNC_STAGES+1 in bypass); free-running, no backpressure.
module io_in_filter import io_ring_pkg::*; #(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int FILT_LEN    = FILT_LEN_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic i_pad,
    input  logic i_bypass,
    output logic o_q
);

    localparam int            CW       = filt_cnt_w(FILT_LEN);
    localparam logic [CW-1:0] CNT_LAST = CW'(FILT_LEN - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_q;
    logic [CW-1:0]          r_cnt;
    logic                   w_s;
    logic                   w_q_nxt;
    logic [CW-1:0]          w_cnt_nxt;

    assign w_s = r_sync[SYNC_STAGES-1];
    assign o_q = r_q;

    // cnt tracks how many consecutive edges s has disagreed with q; any agreement restarts it.
    always_comb begin
        w_q_nxt   = r_q;
        w_cnt_nxt = '0;
        if (i_bypass) begin
            w_q_nxt = w_s;
        end else if (w_s != r_q) begin
            if (r_cnt == CNT_LAST) begin
                w_q_nxt = w_s;
            end else begin
                w_cnt_nxt = r_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= '0;
            r_q    <= 1'b0;
            r_cnt  <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_pad};
            r_q    <= w_q_nxt;
            r_cnt  <= w_cnt_nxt;
        end
    end

endmodule

// File: rtl/io_ring_ctrl.sv
// Pad-ring controller: filtered pad inputs, registered pad outputs, change pulse and saturating transition count.
// Outputs registered (1 cycle); optional IO_LOOPBACK_EN routes filtered inputs back to the pads; no backpressure.
module io_ring_ctrl import io_ring_pkg::*; #(
    parameter int N_IN        = N_IN_DEF,
    parameter int N_OUT       = N_OUT_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int FILT_LEN    = FILT_LEN_DEF
) (
    input  logic           inClock,
    input  logic           inReset,
    io_ring_ctrl_if.slave  bus
);

    logic [N_IN-1:0]  w_q;
    logic [N_IN-1:0]  r_q_d;
    logic [N_IN-1:0]  w_diff;
    logic [N_OUT-1:0] w_pad_src;
    logic [N_OUT-1:0] r_pad_out;
    logic             r_in_change;
    logic [CNT_W-1:0] r_change_count;
    logic [CNT_W-1:0] w_count_nxt;
    logic [15:0]      w_sum;

    for (genvar i = 0; i < N_IN; i++) begin : g_in
        io_in_filter #(
            .SYNC_STAGES (SYNC_STAGES),
            .FILT_LEN    (FILT_LEN)
        ) u_filt (
            .clk      (inClock),
            .rst      (inReset),
            .i_pad    (bus.in_padIn[i]),
            .i_bypass (bus.in_filtBypass),
            .o_q      (w_q[i])
        );
    end

    // Comparing q against its own one-cycle-old copy puts the pulse and the count update on the same edge.
    assign w_diff = w_q ^ r_q_d;

    always_comb begin
        w_count_nxt = '0;
        w_sum       = 16'(r_change_count);
        for (int i = 0; i < N_IN; i++) begin
            w_sum = w_sum + 16'(w_diff[i]);
        end
        if (bus.in_countClear) begin
            w_count_nxt = '0;
        end else if (w_sum > 16'(CNT_MAX)) begin
            w_count_nxt = CNT_MAX;
        end else begin
            w_count_nxt = w_sum[CNT_W-1:0];
        end
    end

`ifdef IO_LOOPBACK_EN
    logic [N_OUT-1:0] w_loop;

    for (genvar j = 0; j < N_OUT; j++) begin : g_loop
        assign w_loop[j] = w_q[j % N_IN];
    end

    assign w_pad_src = bus.in_loopback ? w_loop : bus.in_coreOut;
`else
    assign w_pad_src = bus.in_coreOut;
`endif

    always_ff @(posedge inClock or posedge inReset) begin
        if (inReset) begin
            r_q_d          <= '0;
            r_pad_out      <= '0;
            r_in_change    <= 1'b0;
            r_change_count <= '0;
        end else begin
            r_q_d          <= w_q;
            r_in_change    <= |w_diff;
            r_change_count <= w_count_nxt;
            if (!bus.in_outHold) begin
                r_pad_out <= w_pad_src;
            end
        end
    end

    assign bus.out_coreIn      = w_q;
    assign bus.out_padOut      = r_pad_out;
    assign bus.out_inChange    = r_in_change;
    assign bus.out_changeCount = r_change_count;

endmodule

// File: tb/tb_io_ring_ctrl.sv
// Randomised plus directed bench for io_ring_ctrl: a window-based reference model feeds a scoreboard checked every cycle.
module tb_io_ring_ctrl;
    import io_ring_pkg::*;

    localparam int NI = N_IN_DEF;
    localparam int NO = N_OUT_DEF;
    localparam int SS = SYNC_STAGES_DEF;
    localparam int FL = FILT_LEN_DEF;

    typedef struct packed {
        logic [NI-1:0] core_in;
        logic [NO-1:0] pad_out;
        logic          chg;
        logic [7:0]    cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    io_ring_ctrl_if #(.N_IN(NI), .N_OUT(NO)) bus ();

    io_ring_ctrl #(
        .N_IN(NI), .N_OUT(NO), .SYNC_STAGES(SS), .FILT_LEN(FL)
    ) dut (
        .inClock (clk),
        .inReset (rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t sb[$];

    // Reference model: pad samples travel through an SS-deep delay line; a bit flips only when
    // the last FL delayed samples all disagree with it and none of those edges were in bypass.
    logic [NI-1:0] m_q, m_qd;
    logic [NO-1:0] m_pad;
    logic          m_chg;
    int            m_cnt;
    logic [NI-1:0] m_sq[$];
    logic [NI-1:0] m_sh[$];
    bit            m_bh[$];

    task automatic m_reset();
        m_q = '0; m_qd = '0; m_pad = '0; m_chg = 1'b0; m_cnt = 0;
        m_sq.delete(); m_sh.delete(); m_bh.delete();
        for (int k = 0; k < SS; k++) m_sq.push_back('0);
        for (int k = 0; k < FL; k++) begin
            m_sh.push_back('0);
            m_bh.push_back(1'b0);
        end
    endtask

    task automatic m_step();
        logic [NI-1:0] s, diff, hs;
        logic [NO-1:0] loopv;
        int            sum;
        bit            lb, ok;
        s = m_sq.pop_front();
        m_sq.push_back(bus.in_padIn);
        void'(m_sh.pop_front());
        m_sh.push_back(s);
        void'(m_bh.pop_front());
        m_bh.push_back(bus.in_filtBypass);

        diff  = m_q ^ m_qd;
        sum   = m_cnt + $countones(diff);
        m_cnt = bus.in_countClear ? 0 : ((sum > 255) ? 255 : sum);
        m_chg = (diff != '0);

        for (int j = 0; j < NO; j++) loopv[j] = m_q[j % NI];
        lb = 1'b0;
`ifdef IO_LOOPBACK_EN
        lb = bus.in_loopback;
`endif
        if (!bus.in_outHold) m_pad = lb ? loopv : bus.in_coreOut;

        m_qd = m_q;
        if (bus.in_filtBypass) begin
            m_q = s;
        end else begin
            for (int i = 0; i < NI; i++) begin
                ok = 1'b1;
                for (int k = 0; k < FL; k++) begin
                    hs = m_sh[k];
                    if (m_bh[k] || (hs[i] == m_q[i])) ok = 1'b0;
                end
                if (ok) m_q[i] = ~m_q[i];
            end
        end
    endtask

    always @(posedge clk) begin
        exp_t e;
        if (rst) m_reset();
        else     m_step();
        e.core_in = m_q;
        e.pad_out = m_pad;
        e.chg     = m_chg;
        e.cnt     = 8'(m_cnt);
        sb.push_back(e);
    end

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            n_cmp++;
            if (bus.out_coreIn !== e.core_in || bus.out_padOut !== e.pad_out ||
                bus.out_inChange !== e.chg || bus.out_changeCount !== e.cnt) begin
                n_bad++;
                $display("FAIL scoreboard @%0t: coreIn %h want %h, padOut %h want %h, inChange %b want %b, count %0d want %0d",
                         $time, bus.out_coreIn, e.core_in, bus.out_padOut, e.pad_out,
                         bus.out_inChange, e.chg, bus.out_changeCount, e.cnt);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_coreIn"}, 32'(bus.out_coreIn), 0);
        chk({tag, "_padOut"}, 32'(bus.out_padOut), 0);
        chk({tag, "_inChange"}, 32'(bus.out_inChange), 0);
        chk({tag, "_count"}, 32'(bus.out_changeCount), 0);
    endtask

    initial begin
        int pulses, first, ch;
        bus.in_padIn      = '0;
        bus.in_coreOut    = '0;
        bus.in_filtBypass = 1'b0;
        bus.in_outHold    = 1'b0;
        bus.in_countClear = 1'b0;
`ifdef IO_LOOPBACK_EN
        bus.in_loopback   = 1'b0;
`endif
        rst = 1'b1;
        cyc(3);
        chk_zero("reset_init");
        rst = 1'b0;
        cyc(4);

        // 0->1 step on channel 5
        bus.in_padIn[5] = 1'b1;
        pulses = 0; first = -1;
        for (int n = 1; n <= 10; n++) begin
            cyc(1);
            pulses += int'(bus.out_inChange);
            if (first < 0 && bus.out_coreIn[5]) first = n;
        end
        chk("pass_latency_6pm1", 32'(first >= 5 && first <= 7), 1);
        chk("pass_pulses", 32'(pulses), 1);
        chk("pass_count", 32'(bus.out_changeCount), 1);

        // 3-cycle glitch on channel 0 must not pass the filter
        bus.in_padIn[0] = 1'b1;
        pulses = 0;
        repeat (3) begin cyc(1); pulses += int'(bus.out_inChange); end
        bus.in_padIn[0] = 1'b0;
        repeat (12) begin cyc(1); pulses += int'(bus.out_inChange); end
        chk("reject_coreIn0", 32'(bus.out_coreIn[0]), 0);
        chk("reject_pulses", 32'(pulses), 0);
        chk("reject_count", 32'(bus.out_changeCount), 1);

        // Same glitch with bypass: visible after 3 edges, two transitions counted
        bus.in_filtBypass = 1'b1;
        cyc(2);
        bus.in_padIn[0] = 1'b1;
        cyc(2);
        chk("bypass_edge2", 32'(bus.out_coreIn[0]), 0);
        cyc(1);
        chk("bypass_edge3", 32'(bus.out_coreIn[0]), 1);
        bus.in_padIn[0] = 1'b0;
        pulses = 0;
        repeat (12) begin cyc(1); pulses += int'(bus.out_inChange); end
        chk("bypass_pulses", 32'(pulses), 2);
        chk("bypass_count", 32'(bus.out_changeCount), 3);
        bus.in_filtBypass = 1'b0;
        cyc(2);

        // Saturation: 300 filtered toggles on random channels
        repeat (300) begin
            ch = $urandom_range(NI - 1, 0);
            bus.in_padIn[ch] = ~bus.in_padIn[ch];
            cyc(5);
        end
        cyc(10);
        chk("sat_count", 32'(bus.out_changeCount), 255);

        // Clear coincident with a count increment wins
        bus.in_padIn[3] = ~bus.in_padIn[3];
        cyc(6);
        bus.in_countClear = 1'b1;
        cyc(1);
        bus.in_countClear = 1'b0;
        cyc(6);
        chk("clear_count", 32'(bus.out_changeCount), 0);
        bus.in_padIn[3] = ~bus.in_padIn[3];
        cyc(10);
        chk("after_clear_count", 32'(bus.out_changeCount), 1);

        // Output register and hold
        bus.in_coreOut = 10'h2A5;
        cyc(1);
        chk("pad_2A5", 32'(bus.out_padOut), 32'h2A5);
        bus.in_outHold = 1'b1;
        bus.in_coreOut = 10'h15A;
        cyc(3);
        chk("pad_hold", 32'(bus.out_padOut), 32'h2A5);
        bus.in_outHold = 1'b0;
        cyc(1);
        chk("pad_release", 32'(bus.out_padOut), 32'h15A);

        // Random traffic: frequent glitches on channels 0..3, sparse flips elsewhere
        repeat (2000) begin
            if ($urandom_range(3, 0) == 0) begin
                ch = $urandom_range(3, 0);
                bus.in_padIn[ch] = ~bus.in_padIn[ch];
            end
            if ($urandom_range(15, 0) == 0) begin
                ch = $urandom_range(NI - 1, 0);
                bus.in_padIn[ch] = ~bus.in_padIn[ch];
            end
            if ($urandom_range(63, 0) == 0) bus.in_filtBypass = ~bus.in_filtBypass;
            bus.in_outHold    = ($urandom_range(3, 0) == 0);
            bus.in_countClear = ($urandom_range(31, 0) == 0);
            bus.in_coreOut    = NO'($urandom);
            cyc(1);
        end
        bus.in_filtBypass = 1'b0;
        bus.in_outHold    = 1'b0;
        bus.in_countClear = 1'b0;

`ifdef IO_LOOPBACK_EN
        bus.in_filtBypass = 1'b1;
        bus.in_padIn      = NI'(10'h0F3);
        cyc(6);
        bus.in_loopback   = 1'b1;
        bus.in_coreOut    = 10'h30C;
        cyc(1);
        chk("loopback_pad", 32'(bus.out_padOut), 32'h0F3);
        bus.in_loopback   = 1'b0;
        bus.in_filtBypass = 1'b0;
        cyc(2);
`endif

        // Asynchronous reset mid-cycle with everything driven high
        bus.in_padIn   = '1;
        bus.in_coreOut = '1;
        cyc(12);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk_zero("reset_async");
        cyc(3);
        chk_zero("reset_held");
        rst = 1'b0;
        cyc(12);

        @(negedge clk);
        #1;
        chk("sb_drain", 32'(sb.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/io_ring_ctrl.md
# io_ring_ctrl

Parametrised pad-ring controller between the ITP/BU12SP pad cells and the `TOP` core. It replaces direct pad-to-core wiring with per-input synchronisers, per-input glitch filters and registered outputs. It also counts input transitions for bring-up. The pad cells themselves stay in the chip-level wrapper; this block sits between their `Y`/`A` pins and the core ports.

## Interface
- `N_IN`, default 28: number of input channels, excluding clock and reset.
- `N_OUT`, default 10: number of output channels.
- `SYNC_STAGES`, default 2: synchroniser depth. Must be ≥ 2.
- `FILT_LEN`, default 4: number of consecutive stable cycles required before a filtered input changes. Must be ≥ 1.
- `inClock`  in  1: the single clock.
- `inReset`  in  1: reset, asynchronous, active-high.
- `in_padIn`  in  N_IN: from the ITP `Y` pins; asynchronous to `inClock`.
- `out_coreIn`  out  N_IN: filtered inputs to the core.
- `in_coreOut`  in  N_OUT: core outputs.
- `out_padOut`  out  N_OUT: to the BU12SP `A` pins.
- `in_filtBypass`  in  1: when 1, the glitch filter is skipped on all channels.
- `in_outHold`  in  1: when 1, `out_padOut` is frozen.
- `in_countClear`  in  1: synchronous clear of the transition counter.
- `out_inChange`  out  1: one-cycle pulse when any `out_coreIn` bit changes.
- `out_changeCount`  out  8: saturating count of filtered transitions.
- `in_loopback`  in  1: present only with `IO_LOOPBACK_EN`; loopback select.

## Operation
- **Synchroniser:** each channel has a `SYNC_STAGES`-deep flop chain. Its output is `s[i]`.
- **Filter (per channel):** state is the held value `q[i]` and a counter `cnt[i]` of width `$clog2(FILT_LEN)`, minimum 1.
  - If `s != q` and `cnt == FILT_LEN-1`: `q <= s`, `cnt <= 0`.
  - Else if `s != q`: `cnt <= cnt+1`.
  - Else (`s == q`): `cnt <= 0`.
  - Consequence: a pulse at `s` shorter than `FILT_LEN` cycles never reaches `q`.
  - `FILT_LEN = 1` degenerates to a single register.
- **Bypass:** when `in_filtBypass` = 1, `q <= s` every cycle and `cnt <= 0`. Toggling bypass mid-count discards the partial count, with no spurious update.
- `out_coreIn = q`.
- **Change detect:** `out_inChange` is registered; it is 1 in the cycle after any bit of `q` updates.
- **Transition counter:**
  - `out_changeCount` adds the popcount of bits of `q` that changed this cycle, saturating at 255.
  - `in_countClear` sets it to 0 and takes priority over a simultaneous increment.
- **Output path:**
  - `out_padOut <= in_coreOut` each cycle.
  - When `in_outHold` = 1, `out_padOut` keeps its value.
- **Reset:** `inReset` asserted clears every flop immediately, mid-filter or mid-count included: sync chains, `q`, `cnt`, `out_padOut`, `out_inChange` and `out_changeCount` all go to 0. The first rising edge after deassertion resumes normal operation.

## Timing
- `in_padIn` edge to `out_coreIn`: `SYNC_STAGES + FILT_LEN` clock edges, plus up to one cycle of sampling uncertainty.
- The same path with bypass: `SYNC_STAGES + 1` edges.
- `out_coreIn` change to `out_inChange` pulse: 1 cycle.
- `out_coreIn` change to `out_changeCount` update: 1 cycle, coincident with `out_inChange`.
- `in_coreOut` to `out_padOut`: 1 cycle. Hold takes effect on the same edge it is sampled.
- Reset values: all outputs are 0.

## Configuration
- `IO_LOOPBACK_EN` defined:
  - `in_loopback` port exists.
  - When `in_loopback` = 1, `out_padOut[j] <= out_coreIn[j % N_IN]` instead of `in_coreOut[j]`, with 1-cycle latency.
  - `in_outHold` still has priority.
  - This is used for board-level pad continuity test without a core.
- `IO_LOOPBACK_EN` undefined: the port and mux are absent; the output path is exactly as in Operation.

## Structure
- Package `io_ring_pkg` holds:
  - default values of `N_IN`, `N_OUT`, `SYNC_STAGES`, `FILT_LEN`;
  - `CNT_W = 8` and `CNT_MAX = 8'hFF`;
  - a function returning the filter counter width from `FILT_LEN`.
- Sub-module `io_in_filter`: one channel's synchroniser and filter, with its own `SYNC_STAGES`/`FILT_LEN` parameters. It is instantiated `N_IN` times in a generate loop.
- Counter, change detect, output register and loopback mux live in the top.

## Test plan
- **Reset:** assert `inReset` asynchronously mid-cycle with `in_padIn` = all-ones and `in_coreOut` = `10'h3FF`. All outputs read 0 before the next edge and stay 0 while reset is held.
- **Filter pass** (defaults): a 0→1 step on `in_padIn[5]` gives `out_coreIn[5]` = 1 after 6 edges (±1), `out_inChange` pulses once, and `out_changeCount` = 1.
- **Filter reject:** a 3-cycle pulse on `in_padIn[0]` leaves `out_coreIn[0]` at 0, `out_inChange` never pulses and the count is unchanged. The same 3-cycle pulse with `in_filtBypass` = 1 propagates after 3 edges and the count increments by 2.
- **Saturation and clear:**
  - 300 filtered toggles give `out_changeCount` = 255.
  - `in_countClear` asserted together with a toggle leaves the count at 0.
  - The next toggle gives 1.
- **Output:**
  - `in_coreOut` = `10'h2A5` gives `out_padOut` = `10'h2A5` after 1 edge.
  - Then `in_outHold` = 1 with `in_coreOut` = `10'h15A` keeps `out_padOut` at `10'h2A5`.
  - Releasing hold gives `10'h15A` after 1 edge.
- **Loopback** (`IO_LOOPBACK_EN`): `in_loopback` = 1 with `out_coreIn[9:0]` = `10'h0F3` gives `out_padOut` = `10'h0F3` one cycle later, and `in_coreOut` is ignored.
